// File: rtl/skid_buffer.sv
// Two-entry elastic pipeline register: in_ready comes only from registered state, so out_ready never reaches it.
// Optional macro SKID_BUFFER_FLUSH_EN adds a synchronous flush port for squashing all buffered entries.
module skid_buffer #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
`ifdef SKID_BUFFER_FLUSH_EN
    input  logic             flush,
`endif
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             out_valid_q, out_valid_d;
    logic             not_full_q, not_full_d;
    logic [1:0]       count_q, count_d;
    logic             flush_s;
    logic             in_xfer_s;
    logic             out_xfer_s;

`ifdef SKID_BUFFER_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    assign in_ready   = not_full_q & ~reset & ~flush_s;
    assign out_valid  = out_valid_q;
    assign out_data   = main_q;
    assign count      = count_q;
    assign in_xfer_s  = in_valid & in_ready;
    assign out_xfer_s = out_valid_q & out_ready;

    // Next-state and data-register selection for the handshake transfers
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_xfer_s) begin
                    main_d  = in_data;
                    state_d = BUSY;
                end else begin
                    state_d = EMPTY;
                end
            end
            BUSY: begin
                if (in_xfer_s && out_xfer_s) begin
                    main_d = in_data;
                end else if (in_xfer_s) begin
                    skid_d  = in_data;
                    state_d = FULL;
                end else if (out_xfer_s) begin
                    state_d = EMPTY;
                end else begin
                    state_d = BUSY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the pop can happen
                if (out_xfer_s) begin
                    main_d  = skid_q;
                    state_d = BUSY;
                end else begin
                    state_d = FULL;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Output decodes precomputed from the next state so they leave the flops directly
    always_comb begin
        out_valid_d = 1'b0;
        not_full_d  = 1'b1;
        count_d     = 2'd0;
        case (state_d)
            EMPTY: begin
                out_valid_d = 1'b0;
                not_full_d  = 1'b1;
                count_d     = 2'd0;
            end
            BUSY: begin
                out_valid_d = 1'b1;
                not_full_d  = 1'b1;
                count_d     = 2'd1;
            end
            FULL: begin
                out_valid_d = 1'b1;
                not_full_d  = 1'b0;
                count_d     = 2'd2;
            end
            default: begin
                out_valid_d = 1'b0;
                not_full_d  = 1'b1;
                count_d     = 2'd0;
            end
        endcase
    end

    // State and data registers; reset outranks flush, flush outranks handshakes
    always_ff @(posedge clk) begin
        if (reset || flush_s) begin
            state_q     <= EMPTY;
            main_q      <= RESET_VALUE;
            skid_q      <= RESET_VALUE;
            out_valid_q <= 1'b0;
            not_full_q  <= 1'b1;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            not_full_q  <= not_full_d;
            count_q     <= count_d;
        end
    end

endmodule

// File: tb/tb_skid_buffer.sv
// Directed self-checking bench for skid_buffer; flush scenario runs when SKID_BUFFER_FLUSH_EN is defined.
module tb_skid_buffer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [1:0]  count;
`ifdef SKID_BUFFER_FLUSH_EN
    logic        flush;
`endif

    int tests_run_r;
    int tests_failed_r;

    skid_buffer #(.WIDTH(32), .RESET_VALUE(32'd0)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
`ifdef SKID_BUFFER_FLUSH_EN
        .flush     (flush),
`endif
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run_r++;
        if (obs !== exp) begin
            tests_failed_r++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run_r    = 0;
        tests_failed_r = 0;
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD;
        out_ready = 1'b0;
`ifdef SKID_BUFFER_FLUSH_EN
        flush     = 1'b0;
`endif
        #1;
        check_val("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
        step();
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_count", {30'd0, count}, 32'd0);
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("rst_out_data", out_data, 32'd0);

        // streaming: each value appears one cycle after acceptance
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = i;
            check_val("stream_in_ready", {31'd0, in_ready}, 32'd1);
            step();
            check_val("stream_out_valid", {31'd0, out_valid}, 32'd1);
            check_val("stream_out_data", out_data, i);
            check_val("stream_count", {30'd0, count}, 32'd1);
        end
        in_valid = 1'b0;
        step();
        check_val("stream_drain", {31'd0, out_valid}, 32'd0);

        // backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        step();
        in_data = 32'hB;
        step();
        check_val("bp_count_full", {30'd0, count}, 32'd2);
        check_val("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check_val("bp_head_a", out_data, 32'hA);
        in_data = 32'hC;
        step();
        check_val("bp_hold_count", {30'd0, count}, 32'd2);
        check_val("bp_hold_head", out_data, 32'hA);
        out_ready = 1'b1;
        step();
        check_val("bp_pop_b", out_data, 32'hB);
        check_val("bp_pop_count", {30'd0, count}, 32'd1);
        check_val("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
        step();
        check_val("bp_pop_c", out_data, 32'hC);
        check_val("bp_c_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        step();
        check_val("bp_empty", {31'd0, out_valid}, 32'd0);

        // FULL with in_valid and out_ready together: pop only
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h10;
        step();
        in_data = 32'h11;
        step();
        in_data   = 32'hE;
        out_ready = 1'b1;
        step();
        check_val("sim_count", {30'd0, count}, 32'd1);
        check_val("sim_head", out_data, 32'h11);
        check_val("sim_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check_val("sim_e_out", out_data, 32'hE);
        check_val("sim_e_count", {30'd0, count}, 32'd1);
        in_valid = 1'b0;
        step();
        check_val("sim_empty", {30'd0, count}, 32'd0);

        // reset while FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h20;
        step();
        in_data = 32'h21;
        step();
        check_val("mrst_full", {30'd0, count}, 32'd2);
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        check_val("mrst_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        reset = 1'b0;
        #1;
        check_val("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("mrst_count", {30'd0, count}, 32'd0);
        check_val("mrst_out_data", out_data, 32'd0);
        out_ready = 1'b1;
        step();
        check_val("mrst_no_stale", {31'd0, out_valid}, 32'd0);

`ifdef SKID_BUFFER_FLUSH_EN
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h30;
        step();
        in_data = 32'h31;
        step();
        flush   = 1'b1;
        in_data = 32'h7;
        #1;
        check_val("flush_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_val("flush_count", {30'd0, count}, 32'd0);
        check_val("flush_out_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        step();
        check_val("flush_no_7", {31'd0, out_valid}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run_r, tests_failed_r);
        $finish;
    end

endmodule
